keccak_share_compress: RTL and testbench
========================================

KECCAK_SHARE_COMPRESS -- requirements
Module: keccak_share_compress

Interface
REQ-001 SHALL have parameter d, default 3, meaning security order; input shares per bit (d+1)^2, output shares per bit d+1.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports ap, bp, cp, dp, ep  input  (d+1)**2 each  expanded chi output shares, share index i*(d+1)+j.
REQ-005 SHALL have port in_valid  input  1  expanded shares on ap..ep are valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts the input this cycle.
REQ-007 SHALL have ports ao, bo, co, do_, eo  output  d+1 each  compressed output shares, share index i.
REQ-008 SHALL have port out_valid  output  1  ao..eo hold a valid compressed result.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the output this cycle.

Function
REQ-010 SHALL implement a two-stage pipeline: stage 1 register S (5*(d+1)^2 bits) with valid v1, and stage 2 register O (5*(d+1) bits) with valid v2.
REQ-011 SHALL load S from ap..ep unmodified when in_valid && in_ready (glitch barrier; no logic between the input ports and S).
REQ-012 SHALL compute each output share as an XOR over j=0..d of S[i*(d+1)+j] for each of the five bits, i=0..d, and register the result in O.
REQ-013 SHALL never combine shares with different i before the stage-2 register; compression reads S only, never ap..ep.
REQ-014 SHALL drive ao..eo directly from O and out_valid directly from v2 (no combinational path from inputs).
REQ-015 SHALL load O (and set v2) when v1 && (!v2 || out_ready); v2 clears when out_ready && !v1 in that cycle.
REQ-016 SHALL drive in_ready = !v1 || !v2 || out_ready; v1 sets on an accept and clears when S moves to O without a new accept.
REQ-017 SHALL, on simultaneous accept and stage-1-to-stage-2 transfer, load the new input into S and keep v1 = 1.
REQ-018 SHALL have latency of exactly 2 cycles from accept to out_valid with out_ready held high, and sustain throughput of 1 result/cycle.
REQ-019 SHALL hold S, O, ao..eo stable while stalled (v2 && !out_ready); a full pipeline (v1 && v2 && !out_ready) drives in_ready = 0 and ignores in_valid.
REQ-020 SHALL keep the unmasked value preserved: XOR of all d+1 output shares of a bit equals XOR of all (d+1)^2 input shares of that bit.
REQ-021 SHALL not consume or generate randomness; all freshness comes from the upstream s-box masks.
REQ-022 SHALL accept in_valid/out_ready toggling on any cycle without loss or duplication of results.

Reset
REQ-023 SHALL, while rst_i is high, asynchronously clear S, O, v1, v2 to 0, giving out_valid = 0, ao..eo = 0, in_ready = 1.
REQ-024 SHALL discard any in-flight data when rst_i asserts mid-operation; the first result after deassertion comes only from a post-reset accept.
REQ-025 SHALL ignore in_valid while rst_i is high.

Verification
REQ-026 SHALL cover: reset, d=3 -> out_valid=0, in_ready=1, ao..eo=4'h0 during and after reset.
REQ-027 SHALL cover: d=3, ap=16'h8001, others 0, in_valid 1 cycle, out_ready=1 -> 2 cycles later ao=4'b1001, out_valid=1 for 1 cycle, XOR of ao = 0.
REQ-028 SHALL cover: 10 back-to-back random 16-bit share vectors, out_ready=1 -> 10 consecutive out_valid cycles in order, each share i = XOR of input bits i*4..i*4+3.
REQ-029 SHALL cover: out_ready=0 for 5 cycles after 3 accepts -> 2 held in the pipeline, in_ready=0 from the third cycle, O unchanged; release -> results in order, none lost.
REQ-030 SHALL cover: rst_i pulsed with v1=v2=1 -> out_valid drops immediately (asynchronously), no stale result emitted afterwards.
REQ-031 SHALL cover: end-to-end with the masked s-box, d=3, random unmasked a..e and masks -> XOR of output shares equals chi(a..e) for 1000 vectors.

Source files
------------

// File: rtl/keccak_share_compress.sv
// Two-stage share compression for a masked Keccak chi: register the (d+1)^2 expanded
// shares of each lane bit, then XOR each row i down to one share in a second register.
module keccak_share_compress #(
  parameter int d = 3
) (
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic [(d+1)**2-1:0]  ap,
  input  logic [(d+1)**2-1:0]  bp,
  input  logic [(d+1)**2-1:0]  cp,
  input  logic [(d+1)**2-1:0]  dp,
  input  logic [(d+1)**2-1:0]  ep,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [d:0]           ao,
  output logic [d:0]           bo,
  output logic [d:0]           co,
  output logic [d:0]           do_,
  output logic [d:0]           eo,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int N  = d + 1;
  localparam int NS = N * N;

  // Handshake: a transfer happens on a port in any cycle where valid && ready are both
  // high at the rising clock edge; valid never depends on ready.
  logic [4:0][NS-1:0] s_q, s_d;
  logic [4:0][N-1:0]  o_q, o_d;
  logic [4:0][N-1:0]  comp;
  logic               v1_q, v1_d;
  logic               v2_q, v2_d;
  logic               accept;
  logic               xfer;

  // Each output share only mixes shares of the same row i, read from the glitch barrier S.
  always_comb begin
    comp = '0;
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < N; i++) begin
        comp[b][i] = ^s_q[b][i*N +: N];
      end
    end
  end

  always_comb begin
    in_ready = !v1_q || !v2_q || out_ready;
    accept   = in_valid && in_ready;
    xfer     = v1_q && (!v2_q || out_ready);
    s_d      = s_q;
    o_d      = o_q;
    v1_d     = v1_q;
    v2_d     = v2_q;
    if (accept) begin
      s_d = {ep, dp, cp, bp, ap};
    end
    if (xfer) begin
      o_d  = comp;
      v2_d = 1'b1;
    end else if (out_ready) begin
      v2_d = 1'b0;
    end
    if (accept) begin
      v1_d = 1'b1;
    end else if (xfer) begin
      v1_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      s_q  <= '0;
      o_q  <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      s_q  <= s_d;
      o_q  <= o_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
    end
  end

  assign ao        = o_q[0];
  assign bo        = o_q[1];
  assign co        = o_q[2];
  assign do_       = o_q[3];
  assign eo        = o_q[4];
  assign out_valid = v2_q;

endmodule

// File: tb/tb_keccak_share_compress.sv
// Bench for keccak_share_compress: directed cases plus random traffic checked every
// cycle against a transaction-level model (occupancy, age and expected result queues).
module tb_keccak_share_compress;

  localparam int D  = 3;
  localparam int N  = D + 1;
  localparam int NS = N * N;
  localparam int W  = 5 * N;

  logic          clk;
  logic          rst_i;
  logic [NS-1:0] ap, bp, cp, dp, ep;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  ao, bo, co, do_, eo;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    cur_chi;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_acc  = 0;

  logic [W-1:0] exp_q[$];
  int           stamp_q[$];
  logic [4:0]   chi_q[$];
  logic         held_v;
  logic [W-1:0] held_o;

  keccak_share_compress #(.d(D)) dut (
    .clk(clk), .rst_i(rst_i),
    .ap(ap), .bp(bp), .cp(cp), .dp(dp), .ep(ep),
    .in_valid(in_valid), .in_ready(in_ready),
    .ao(ao), .bo(bo), .co(co), .do_(do_), .eo(eo),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: share (i,j) of a bit is element i*N+j; output share i is the parity of row i.
  function automatic logic [W-1:0] model_out(input logic [NS-1:0] a, b, c, dd, e);
    logic [NS-1:0] lanes [5];
    logic [W-1:0]  r;
    lanes[0] = a; lanes[1] = b; lanes[2] = c; lanes[3] = dd; lanes[4] = e;
    r = '0;
    for (int l = 0; l < 5; l++) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          r[l*N+i] = r[l*N+i] ^ lanes[l][i*N+j];
        end
      end
    end
    return r;
  endfunction

  function automatic logic [4:0] chi(input logic [4:0] row);
    logic [4:0] c;
    for (int x = 0; x < 5; x++) begin
      c[x] = row[x] ^ (~row[(x+1)%5] & row[(x+2)%5]);
    end
    return c;
  endfunction

  // Random expanded sharing whose total parity is the wanted unmasked bit.
  function automatic logic [NS-1:0] mk_shares(input logic bitval);
    logic [31:0]   tmp;
    logic [NS-1:0] v;
    tmp = $urandom;
    v = tmp[NS-1:0];
    v[NS-1] = (^v[NS-2:0]) ^ bitval;
    return v;
  endfunction

  // Driver: one cycle of random traffic, inputs applied 1 time unit after the edge.
  task automatic drive_rand(input int pv, input int pr);
    logic [31:0] tmp;
    logic [4:0]  c;
    tmp = $urandom;
    c = chi(tmp[4:0]);
    ap = mk_shares(c[0]); bp = mk_shares(c[1]); cp = mk_shares(c[2]);
    dp = mk_shares(c[3]); ep = mk_shares(c[4]);
    cur_chi   = c;
    in_valid  = ($urandom_range(0, 99) < pv);
    out_ready = ($urandom_range(0, 99) < pr);
    @(posedge clk); #1;
  endtask

  // Scoreboard / compare process, sampled on the falling edge.
  always @(negedge clk) begin
    logic exp_ready;
    logic exp_ov;
    cyc++;
    if (rst_i) begin
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_outputs", {eo, do_, co, bo, ao}, '0);
      exp_q.delete(); stamp_q.delete(); chi_q.delete();
      held_v = 1'b0;
    end else begin
      exp_ready = (exp_q.size() < 2) || out_ready;
      exp_ov = (exp_q.size() > 0) && (cyc - stamp_q[0] >= 2);
      check("in_ready", in_ready, exp_ready);
      check("out_valid", out_valid, exp_ov);
      if (held_v) check("stall_hold", {eo, do_, co, bo, ao}, held_o);
      if (out_valid && out_ready && exp_q.size() > 0) begin
        check("data", {eo, do_, co, bo, ao}, exp_q[0]);
        check("chi", {^eo, ^do_, ^co, ^bo, ^ao}, chi_q[0]);
        void'(exp_q.pop_front()); void'(stamp_q.pop_front()); void'(chi_q.pop_front());
      end
      held_v = out_valid && !out_ready;
      held_o = {eo, do_, co, bo, ao};
      if (in_valid && exp_ready) begin
        exp_q.push_back(model_out(ap, bp, cp, dp, ep));
        stamp_q.push_back(cyc);
        chi_q.push_back(cur_chi);
        n_acc++;
      end
    end
  end

  initial begin
    int guard;
    rst_i = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ap = '0; bp = '0; cp = '0; dp = '0; ep = '0; cur_chi = '0;
    held_v = 1'b0; held_o = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(posedge clk); #1;
    check("post_rst_out_valid", out_valid, 1'b0);
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_ao", ao, 4'h0);

    // Single vector, latency 2, one-cycle output pulse.
    out_ready = 1'b1; ap = 16'h8001; in_valid = 1'b1; cur_chi = 5'b00000;
    @(posedge clk); #1;
    in_valid = 1'b0; ap = '0;
    check("lat_early", out_valid, 1'b0);
    @(posedge clk); #1;
    check("lat_valid", out_valid, 1'b1);
    check("lat_ao", ao, 4'b1001);
    check("lat_ao_parity", ^ao, 1'b0);
    @(posedge clk); #1;
    check("lat_pulse_end", out_valid, 1'b0);

    // Back-to-back stream.
    for (int k = 0; k < 10; k++) drive_rand(100, 100);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Stall with a full pipeline, then release.
    for (int k = 0; k < 5; k++) drive_rand(100, 0);
    check("stall_in_ready", in_ready, 1'b0);
    check("stall_out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Asynchronous reset with both stages full.
    for (int k = 0; k < 3; k++) drive_rand(100, 0);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    rst_i = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Random traffic: at least 1000 vectors through the chi end-to-end check.
    n_acc = 0;
    guard = 0;
    while (n_acc < 1000 && guard < 6000) begin
      drive_rand(75, 70);
      guard++;
    end
    check("random_accept_budget", (n_acc >= 1000), 1'b1);
    in_valid = 1'b0; out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    check("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
